// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: ID-stage forwarding select and stall sequencer for NUM_SRC operands.
// Optional stall-cycle counter is built when ID_HAZARD_PERF_EN is defined.
module id_hazard_ctrl #(
   parameter int ADDR_W      = 5,
   parameter int NUM_SRC     = 2,
   parameter int EX_FWD      = 1,
   parameter int STALL_LD_EX = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_valid_d,
   input  logic [NUM_SRC*ADDR_W-1:0] i_src_addr_d,
   input  logic [NUM_SRC-1:0]        i_src_use_d,
   input  logic                      i_flush_d,
   input  logic                      i_reg_write_e,
   input  logic                      i_mem_to_reg_e,
   input  logic [ADDR_W-1:0]         i_write_reg_addr_e,
   input  logic                      i_reg_write_m,
   input  logic                      i_mem_to_reg_m,
   input  logic [ADDR_W-1:0]         i_write_reg_addr_m,
   input  logic                      i_perf_clr,
   output logic [2*NUM_SRC-1:0]      o_fw_sel,
   output logic                      o_stall_f,
   output logic                      o_stall_d,
   output logic                      o_flush_e,
   output logic [31:0]               o_stall_cycles
);
   localparam logic       IDLE   = 1'b0;
   localparam logic       HOLD   = 1'b1;
   localparam bit         FWD_EX = EX_FWD != 0;
   localparam logic [1:0] LD_EX  = 2'(STALL_LD_EX);
   localparam logic [1:0] ALU_EX = FWD_EX ? 2'd0 : 2'd1;

   logic              r_state;
   logic [1:0]        r_stall_left;
   logic [ADDR_W-1:0] w_addr;
   logic              w_me;
   logic              w_mm;
   logic [1:0]        w_req;
   logic [1:0]        w_need;
   logic              w_detect;
   logic              w_stall;

   // an operand that needs a stall never forwards, so its select stays 00
   always_comb begin
      w_need   = '0;
      o_fw_sel = '0;
      w_addr   = '0;
      w_me     = 1'b0;
      w_mm     = 1'b0;
      w_req    = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         w_addr = i_src_addr_d[i*ADDR_W +: ADDR_W];
         w_me   = i_src_use_d[i] && i_reg_write_e && (i_write_reg_addr_e != '0) && (i_write_reg_addr_e == w_addr);
         w_mm   = i_src_use_d[i] && i_reg_write_m && (i_write_reg_addr_m != '0) && (i_write_reg_addr_m == w_addr);
         w_req  = w_me ? (i_mem_to_reg_e ? LD_EX : ALU_EX) : (w_mm && i_mem_to_reg_m) ? 2'd1 : 2'd0;
         o_fw_sel[2*i +: 2] = (w_me && !i_mem_to_reg_e && FWD_EX) ? 2'b10 :
                              (!w_me && w_mm && !i_mem_to_reg_m) ? 2'b01 : 2'b00;
         if (w_req > w_need) w_need = w_req;
      end
   end

   assign w_detect  = (r_state == IDLE) && i_valid_d && !i_flush_d && (w_need != 2'd0);
   assign w_stall   = rst_n && !i_flush_d && ((r_state == HOLD) || w_detect);
   assign o_stall_f = w_stall;
   assign o_stall_d = w_stall;
   assign o_flush_e = w_stall;

   // HOLD ignores the hazard inputs; IDLE re-evaluates once the hold expires
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_stall_left <= '0;
      end else if (i_flush_d) begin
         r_state      <= IDLE;
         r_stall_left <= '0;
      end else if (r_state == HOLD) begin
         r_stall_left <= r_stall_left - 2'd1;
         r_state      <= (r_stall_left == 2'd1) ? IDLE : HOLD;
      end else if (w_detect) begin
         r_stall_left <= w_need - 2'd1;
         r_state      <= (w_need > 2'd1) ? HOLD : IDLE;
      end
   end

`ifdef ID_HAZARD_PERF_EN
   logic [31:0] r_stall_cycles;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_stall_cycles <= '0;
      else if (i_perf_clr)
         r_stall_cycles <= '0;
      else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF))
         r_stall_cycles <= r_stall_cycles + 32'd1;
   end
   assign o_stall_cycles = r_stall_cycles;
`else
   logic w_unused_perf;
   assign w_unused_perf  = i_perf_clr;
   assign o_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: directed checks of forwarding select, stall sequencing and stall counter.
`timescale 1ns/1ps
module tb_id_hazard_ctrl;
`ifdef ID_HAZARD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_d, flush_d, rwe, mtre, rwm, mtrm, perf_clr;
   logic [9:0]  src;
   logic [1:0]  use_d;
   logic [4:0]  wae, wam;
   logic [3:0]  fw1, fw0;
   logic        sf1, sd1, fe1, sf0, sd0, fe0;
   logic [31:0] cyc1, cyc0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   id_hazard_ctrl #(.ADDR_W(5), .NUM_SRC(2), .EX_FWD(1), .STALL_LD_EX(2)) u_fwd (
      .clk(clk), .rst_n(rst_n), .i_valid_d(valid_d), .i_src_addr_d(src), .i_src_use_d(use_d),
      .i_flush_d(flush_d), .i_reg_write_e(rwe), .i_mem_to_reg_e(mtre), .i_write_reg_addr_e(wae),
      .i_reg_write_m(rwm), .i_mem_to_reg_m(mtrm), .i_write_reg_addr_m(wam), .i_perf_clr(perf_clr),
      .o_fw_sel(fw1), .o_stall_f(sf1), .o_stall_d(sd1), .o_flush_e(fe1), .o_stall_cycles(cyc1));

   id_hazard_ctrl #(.ADDR_W(5), .NUM_SRC(2), .EX_FWD(0), .STALL_LD_EX(2)) u_nfwd (
      .clk(clk), .rst_n(rst_n), .i_valid_d(valid_d), .i_src_addr_d(src), .i_src_use_d(use_d),
      .i_flush_d(flush_d), .i_reg_write_e(rwe), .i_mem_to_reg_e(mtre), .i_write_reg_addr_e(wae),
      .i_reg_write_m(rwm), .i_mem_to_reg_m(mtrm), .i_write_reg_addr_m(wam), .i_perf_clr(perf_clr),
      .o_fw_sel(fw0), .o_stall_f(sf0), .o_stall_d(sd0), .o_flush_e(fe0), .o_stall_cycles(cyc0));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear();
      valid_d = 0; flush_d = 0; rwe = 0; mtre = 0; rwm = 0; mtrm = 0; perf_clr = 0;
      src = '0; use_d = '0; wae = '0; wam = '0;
      tick();
   endtask

   task automatic load_hazard();
      valid_d = 1; src = {5'd0, 5'd9}; use_d = 2'b01; rwe = 1; mtre = 1; wae = 5'd9;
   endtask

   task automatic test_reset();
      clear();
      rst_n = 0;
      #2;
      checks++; if ({sf1, sd1, fe1} !== 3'b000) begin errors++; $display("FAIL reset_stall: got %b expected 000", {sf1, sd1, fe1}); end
      checks++; if (fw1 !== 4'b0000) begin errors++; $display("FAIL reset_fw_sel: got %b expected 0000", fw1); end
      checks++; if (cyc1 !== 32'd0) begin errors++; $display("FAIL reset_cycles: got %0h expected 0", cyc1); end
      rst_n = 1;
      tick();
   endtask

   task automatic test_alu_fwd();
      clear();
      valid_d = 1; src = {5'd0, 5'd8}; use_d = 2'b01; rwe = 1; mtre = 0; wae = 5'd8;
      #2;
      checks++; if (fw1 !== 4'b0010) begin errors++; $display("FAIL alu_fwd_sel: got %b expected 0010", fw1); end
      checks++; if (sf1 !== 1'b0) begin errors++; $display("FAIL alu_fwd_stall: got %b expected 0", sf1); end
      rwm = 1; wam = 5'd8; mtrm = 0;
      #1;
      checks++; if (fw1 !== 4'b0010) begin errors++; $display("FAIL youngest_wins: got %b expected 0010", fw1); end
      rwe = 0; src = {5'd8, 5'd3}; use_d = 2'b11;
      #1;
      checks++; if (fw1 !== 4'b0100) begin errors++; $display("FAIL mem_alu_op1: got %b expected 0100", fw1); end
      use_d = 2'b01;
      #1;
      checks++; if (fw1 !== 4'b0000) begin errors++; $display("FAIL unused_operand: got %b expected 0000", fw1); end
   endtask

   task automatic test_load_ex();
      clear();
      perf_clr = 1;
      tick();
      perf_clr = 0;
      load_hazard();
      #2;
      checks++; if ({sf1, sd1, fe1} !== 3'b111) begin errors++; $display("FAIL load_stall_c1: got %b expected 111", {sf1, sd1, fe1}); end
      checks++; if (fw1 !== 4'b0000) begin errors++; $display("FAIL load_fw_sel: got %b expected 0000", fw1); end
      checks++; if (cyc1 !== 32'd0) begin errors++; $display("FAIL load_cycles_c1: got %0h expected 0", cyc1); end
      tick();
      valid_d = 0;
      #2;
      checks++; if (sf1 !== 1'b1) begin errors++; $display("FAIL load_stall_c2: got %b expected 1", sf1); end
      tick();
      #2;
      checks++; if (sf1 !== 1'b0) begin errors++; $display("FAIL load_stall_c3: got %b expected 0", sf1); end
      checks++; if (cyc1 !== (PERF ? 32'd2 : 32'd0)) begin errors++; $display("FAIL load_cycles: got %0h expected %0h", cyc1, PERF ? 32'd2 : 32'd0); end
   endtask

   task automatic test_max_operands();
      clear();
      valid_d = 1; src = {5'd11, 5'd10}; use_d = 2'b11;
      rwm = 1; mtrm = 1; wam = 5'd10; rwe = 1; mtre = 1; wae = 5'd11;
      #2;
      checks++; if (sf1 !== 1'b1) begin errors++; $display("FAIL max_stall_c1: got %b expected 1", sf1); end
      checks++; if (fw1 !== 4'b0000) begin errors++; $display("FAIL max_fw_sel: got %b expected 0000", fw1); end
      tick();
      valid_d = 0;
      #2;
      checks++; if (sf1 !== 1'b1) begin errors++; $display("FAIL max_stall_c2: got %b expected 1", sf1); end
      tick();
      #2;
      checks++; if (sf1 !== 1'b0) begin errors++; $display("FAIL max_stall_c3: got %b expected 0", sf1); end
      valid_d = 1; src = 10'd0; wae = 5'd0; wam = 5'd0; mtrm = 0;
      #1;
      checks++; if ({sf1, fw1} !== 5'b00000) begin errors++; $display("FAIL reg0_load: got %b expected 00000", {sf1, fw1}); end
      mtre = 0;
      #1;
      checks++; if (fw1 !== 4'b0000) begin errors++; $display("FAIL reg0_alu: got %b expected 0000", fw1); end
   endtask

   task automatic test_ex_fwd0();
      clear();
      valid_d = 1; src = {5'd0, 5'd5}; use_d = 2'b01; rwe = 1; mtre = 0; wae = 5'd5;
      #2;
      checks++; if ({sf0, fw0} !== 5'b10000) begin errors++; $display("FAIL nofwd_c1: got %b expected 10000", {sf0, fw0}); end
      checks++; if ({sf1, fw1} !== 5'b00010) begin errors++; $display("FAIL fwd_ref_c1: got %b expected 00010", {sf1, fw1}); end
      tick();
      valid_d = 0;
      #2;
      checks++; if (sf0 !== 1'b0) begin errors++; $display("FAIL nofwd_c2: got %b expected 0", sf0); end
   endtask

   task automatic test_flush();
      clear();
      load_hazard();
      flush_d = 1;
      #2;
      checks++; if (sf1 !== 1'b0) begin errors++; $display("FAIL flush_idle: got %b expected 0", sf1); end
      flush_d = 0;
      #1;
      checks++; if (sf1 !== 1'b1) begin errors++; $display("FAIL flush_detect: got %b expected 1", sf1); end
      tick();
      flush_d = 1;
      #2;
      checks++; if (sf1 !== 1'b0) begin errors++; $display("FAIL flush_hold: got %b expected 0", sf1); end
      tick();
      flush_d = 0;
      #2;
      checks++; if (sf1 !== 1'b1) begin errors++; $display("FAIL flush_redetect: got %b expected 1", sf1); end
      tick();
      valid_d = 0;
      #2;
      checks++; if (sf1 !== 1'b1) begin errors++; $display("FAIL flush_rehold: got %b expected 1", sf1); end
      tick();
      #2;
      checks++; if (sf1 !== 1'b0) begin errors++; $display("FAIL flush_done: got %b expected 0", sf1); end
   endtask

   task automatic test_reset_mid_hold();
      clear();
      load_hazard();
      tick();
      valid_d = 0;
      #2;
      checks++; if (sf1 !== 1'b1) begin errors++; $display("FAIL rst_pre_hold: got %b expected 1", sf1); end
      rst_n = 0;
      #1;
      checks++; if ({sf1, sd1, fe1, fw1} !== 7'd0) begin errors++; $display("FAIL rst_mid_hold: got %b expected 0000000", {sf1, sd1, fe1, fw1}); end
      checks++; if (cyc1 !== 32'd0) begin errors++; $display("FAIL rst_mid_cycles: got %0h expected 0", cyc1); end
      #2;
      rst_n = 1;
      tick();
      checks++; if (sf1 !== 1'b0) begin errors++; $display("FAIL rst_idle_after: got %b expected 0", sf1); end
   endtask

`ifdef ID_HAZARD_PERF_EN
   task automatic test_saturate();
      clear();
      force u_fwd.r_stall_cycles = 32'hFFFF_FFFE;
      #1;
      release u_fwd.r_stall_cycles;
      load_hazard();
      tick();
      valid_d = 0;
      #1;
      checks++; if (cyc1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_reach: got %0h expected ffffffff", cyc1); end
      tick();
      #1;
      checks++; if (cyc1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold: got %0h expected ffffffff", cyc1); end
   endtask
`endif

   task automatic test_perf_clr();
      clear();
      load_hazard();
      perf_clr = 1;
      tick();
      perf_clr = 0; valid_d = 0;
      #1;
      checks++; if (cyc1 !== 32'd0) begin errors++; $display("FAIL clr_wins: got %0h expected 0", cyc1); end
      tick();
      #1;
      checks++; if (cyc1 !== (PERF ? 32'd1 : 32'd0)) begin errors++; $display("FAIL clr_then_count: got %0h expected %0h", cyc1, PERF ? 32'd1 : 32'd0); end
   endtask

   initial begin
      test_reset();
      test_alu_fwd();
      test_load_ex();
      test_max_operands();
      test_ex_fwd0();
      test_flush();
      test_reset_mid_hold();
`ifdef ID_HAZARD_PERF_EN
      test_saturate();
`endif
      test_perf_clr();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

- Successor to the ID-stage forwarding selector, generalised to `NUM_SRC` source operands.
- Adds a configurable EX-forwarding mode and a registered stall sequencer for branch and jr operands resolved in ID.
- Sits between the decode stage and the EX/MEM pipeline registers:
  - selects the forwarding path per operand;
  - freezes IF/ID and bubbles EX for load-use and late-producer hazards;
  - optionally counts stall cycles.

## Interface
- `ADDR_W`, 5, register address width.
- `NUM_SRC`, 2, number of ID-stage source operands checked.
- `EX_FWD`, 1, 1 = forward EX ALU result into ID; 0 = stall instead.
- `STALL_LD_EX`, 2, stall cycles for a load producer in EX (1..3).
- `clk` in 1, rising-edge clock.
- `rst_n` in 1, asynchronous active-low reset.
- `valid_d` in 1, ID instruction valid.
- `src_addr_d` in `NUM_SRC*ADDR_W`, source register addresses; operand i occupies bits `[i*ADDR_W +: ADDR_W]`.
- `src_use_d` in `NUM_SRC`, operand i is consumed in ID (branch/jr).
- `flush_d` in 1, kill the ID instruction (taken branch/exception).
- `reg_write_e`, `mem_to_reg_e` in 1 each, EX producer writes a register / is a load.
- `write_reg_addr_e` in `ADDR_W`, EX destination register.
- `reg_write_m`, `mem_to_reg_m` in 1 each, MEM producer writes a register / is a load.
- `write_reg_addr_m` in `ADDR_W`, MEM destination register.
- `perf_clr` in 1, synchronous clear of the stall counter.
- `fw_sel` out `2*NUM_SRC`, per operand: 00 none, 10 EX, 01 MEM.
- `stall_f`, `stall_d` out 1 each, hold PC and the IF/ID register.
- `flush_e` out 1, insert a bubble into ID/EX.
- `stall_cycles` out 32, saturating stall-cycle count.

## Operation
- **Match(i, X).** True when `src_use_d[i]`, `reg_write_X`, `write_reg_addr_X != 0`, and `write_reg_addr_X == src_addr_d[i]`.
- **Youngest producer wins.** EX match takes priority over MEM match.
- **Per-operand requirement:**
  - EX match with a load → stall `STALL_LD_EX`.
  - EX match with an ALU result → `fw_sel` 10 if `EX_FWD`=1, otherwise stall 1.
  - MEM match with a load → stall 1.
  - MEM match with an ALU result → `fw_sel` 01.
  - No match → 00.
- **Stall length N.** Maximum requirement over all operands; 0 means no stall.
- **`fw_sel` is purely combinational** and valid in every cycle, including stall cycles. Whenever an operand needs a stall, its `fw_sel` is 00.
- **FSM states:**
  - IDLE. If `valid_d` && !`flush_d` && N>0: assert stalls combinationally this cycle, load `stall_left` = N-1, and go to HOLD if N>1.
  - HOLD. Assert stalls from state; decrement `stall_left`; return to IDLE when it reaches 0.
- **No re-evaluation in HOLD.** Detection is suppressed in HOLD. The first IDLE cycle after HOLD re-evaluates with fresh pipeline state.
- **Stall outputs.** `stall_f` = `stall_d` = `flush_e` = stall asserted.
- **`flush_d` priority.** `flush_d` has priority in any state: stall outputs are 0 in that cycle, `stall_left` clears, and the next state is IDLE.
- **Register 0** never matches.
- **`stall_left` width.** 2 bits.

## Timing
- **Reset values:**
  - state IDLE, `stall_left` 0;
  - `stall_f`/`stall_d`/`flush_e` 0;
  - `stall_cycles` 0;
  - `fw_sel` combinational: 0 whenever nothing matches.
- **Stall duration.** Stall asserts in the detect cycle (zero latency) and holds for exactly N consecutive cycles.
- **Reset mid-HOLD.** Stalls drop asynchronously; the FSM starts in IDLE.
- **Counter update.** `stall_cycles` updates one cycle after each stalled cycle. It saturates at 0xFFFFFFFF. `perf_clr` wins over increment in the same cycle.

## Configuration
- **Macro `ID_HAZARD_PERF_EN`.**
  - Defined: 32-bit saturating `stall_cycles` counter and `perf_clr` are functional.
  - Undefined: the counter logic is not built, `stall_cycles` is tied to 0, and `perf_clr` is ignored. The port list is unchanged.

## Test plan
- **ALU in EX, EX_FWD=1.** beq, src0=r8, `reg_write_e`=1, `write_reg_addr_e`=8, `mem_to_reg_e`=0 → `fw_sel[1:0]`=10, no stall.
- **Youngest wins.** Same EX producer, plus MEM writing r8 → `fw_sel[1:0]`=10.
- **Load in EX, STALL_LD_EX=2.** Load in EX writing r9; jr r9 → stall high exactly 2 cycles, then IDLE; `stall_cycles`=2.
- **Max over operands.** src0 matches a MEM load (1 cycle) and src1 matches an EX load → 2-cycle stall. Writes to r0 are never forwarded or stalled.
- **EX_FWD=0.** ALU producer in EX on r5, beq uses r5 → 1-cycle stall, `fw_sel` 00.
- **Interruptions.**
  - `flush_d` on the 2nd cycle of a 2-cycle stall → stall low that same cycle, IDLE next.
  - `rst_n` low mid-HOLD → all outputs 0 immediately.
  - Counter preset near 0xFFFFFFFF saturates.
  - `perf_clr` together with a stall → 0.
